// File: rtl/vend_ctrl.sv
// Vending machine controller: product selection, coin credit, greedy change and refund from coin banks.
// Optional idle-credit timeout is built only when VEND_TIMEOUT_EN is defined.
module vend_ctrl #(
   parameter int NPROD      = 4,
   parameter int CW         = 8,
   parameter int INIT_COINS = 4,
   parameter int TIMEOUT    = 1000,
   localparam int PW        = $clog2(NPROD)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          sel_valid,
   input  logic [PW-1:0] sel_id,
   input  logic          coin_valid,
   input  logic [1:0]    coin_type,
   input  logic          cancel,
   input  logic          price_wr,
   input  logic [PW-1:0] price_wr_id,
   input  logic [7:0]    price_wr_val,
   output logic          vend_valid,
   output logic [PW-1:0] vend_id,
   output logic          coin_out_valid,
   output logic [1:0]    coin_out_type,
   output logic          coin_rej,
   output logic          sel_err,
   output logic          refund_flag,
   output logic          busy,
   output logic [7:0]    credit,
   output logic [CW-1:0] bank_q,
   output logic [CW-1:0] bank_h,
   output logic [CW-1:0] bank_u,
   output logic [15:0]   sales_total
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] CREDIT = 3'd1;
   localparam logic [2:0] CHECK  = 3'd2;
   localparam logic [2:0] CHANGE = 3'd3;
   localparam logic [2:0] REFUND = 3'd4;

   localparam int MW = (CW > 8) ? CW : 8;

   function automatic logic [7:0] coin_value(input logic [1:0] t);
      case (t)
         2'd0:    coin_value = 8'd1;
         2'd1:    coin_value = 8'd2;
         2'd2:    coin_value = 8'd4;
         default: coin_value = 8'd0;
      endcase
   endfunction

   logic [2:0]    state_reg, state_next;
   logic [7:0]    credit_reg, credit_next;
   logic [7:0]    price_reg, price_next;
   logic [PW-1:0] id_reg, id_next;
   logic [CW-1:0] bank_q_reg, bank_q_next;
   logic [CW-1:0] bank_h_reg, bank_h_next;
   logic [CW-1:0] bank_u_reg, bank_u_next;
   logic [7:0]    ins_q_reg, ins_q_next;
   logic [7:0]    ins_h_reg, ins_h_next;
   logic [7:0]    ins_u_reg, ins_u_next;
   logic [15:0]   sales_reg, sales_next;
   logic          vend_valid_reg, vend_valid_next;
   logic [PW-1:0] vend_id_reg, vend_id_next;
   logic          coin_out_valid_reg, coin_out_valid_next;
   logic [1:0]    coin_out_type_reg, coin_out_type_next;
   logic          coin_rej_reg, coin_rej_next;
   logic          sel_err_reg, sel_err_next;

   // Price table: registered so it can be reset to its default pricing.
   logic [7:0]       price_mem [NPROD];
   logic [NPROD-1:0] price_we;

   genvar gi;
   generate
      for (gi = 0; gi < NPROD; gi++) begin : g_price_we
         assign price_we[gi] = price_wr && (price_wr_id == PW'(gi));
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NPROD; i++) price_mem[i] <= 8'(i + 2);
      end else begin
         for (int i = 0; i < NPROD; i++)
            if (price_we[i]) price_mem[i] <= price_wr_val;
      end
   end

   logic       sel_in_range;
   logic [7:0] sel_price;
   logic       sel_ok;

   assign sel_in_range = 32'(sel_id) < NPROD;
   assign sel_price    = sel_in_range ? price_mem[sel_id] : 8'd0;
   assign sel_ok       = sel_in_range && (sel_price != 8'd0);

   logic [7:0] coin_amt;
   logic       coin_bank_full;
   logic       coin_ok;

   assign coin_amt = coin_value(coin_type);

   always_comb begin
      case (coin_type)
         2'd0:    coin_bank_full = (bank_q_reg == {CW{1'b1}});
         2'd1:    coin_bank_full = (bank_h_reg == {CW{1'b1}});
         2'd2:    coin_bank_full = (bank_u_reg == {CW{1'b1}});
         default: coin_bank_full = 1'b1;
      endcase
   end

   assign coin_ok = (coin_type != 2'd3) && !coin_bank_full &&
                    (({1'b0, credit_reg} + {1'b0, coin_amt}) <= 9'd255);

   // Greedy change plan evaluated in CHECK; only its feasibility is kept,
   // CHANGE re-derives the same largest-first sequence from credit and banks.
   logic [7:0] change_amt, g_u, g_h, g_q, rem_u, rem_h;
   logic       change_ok;

   always_comb begin
      change_amt = credit_reg - price_reg;
      g_u   = (MW'(bank_u_reg) < MW'(change_amt >> 2)) ? 8'(bank_u_reg) : (change_amt >> 2);
      rem_u = change_amt - (g_u << 2);
      g_h   = (MW'(bank_h_reg) < MW'(rem_u >> 1)) ? 8'(bank_h_reg) : (rem_u >> 1);
      rem_h = rem_u - (g_h << 1);
      g_q   = (MW'(bank_q_reg) < MW'(rem_h)) ? 8'(bank_q_reg) : rem_h;
      change_ok = (g_q == rem_h);
   end

`ifdef VEND_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer_reg, timer_next;
`endif

   logic       accept;
   logic       out_fire;
   logic [1:0] out_type;

   always_comb begin
      state_next          = state_reg;
      credit_next         = credit_reg;
      price_next          = price_reg;
      id_next             = id_reg;
      bank_q_next         = bank_q_reg;
      bank_h_next         = bank_h_reg;
      bank_u_next         = bank_u_reg;
      ins_q_next          = ins_q_reg;
      ins_h_next          = ins_h_reg;
      ins_u_next          = ins_u_reg;
      sales_next          = sales_reg;
      vend_valid_next     = 1'b0;
      vend_id_next        = vend_id_reg;
      coin_out_valid_next = 1'b0;
      coin_out_type_next  = coin_out_type_reg;
      coin_rej_next       = 1'b0;
      sel_err_next        = 1'b0;
      accept              = 1'b0;
      out_fire            = 1'b0;
      out_type            = 2'd0;

      case (state_reg)
         IDLE: begin
            if (sel_valid) begin
               if (sel_ok) begin
                  id_next    = sel_id;
                  price_next = sel_price;
                  state_next = CREDIT;
               end else begin
                  sel_err_next = 1'b1;
               end
            end
         end

         CREDIT: begin
            if (coin_valid) begin
               if (coin_ok) accept = 1'b1;
               else         coin_rej_next = 1'b1;
            end
            if (cancel)
               state_next = REFUND;
            else if (credit_reg >= price_reg)
               state_next = CHECK;
`ifdef VEND_TIMEOUT_EN
            else if (!accept && timer_reg == TW'(TIMEOUT - 1))
               state_next = (credit_reg != 8'd0) ? REFUND : IDLE;
`endif
         end

         CHECK: begin
            if (change_ok) begin
               vend_valid_next = 1'b1;
               vend_id_next    = id_reg;
               sales_next      = sales_reg + {8'd0, price_reg};
               credit_next     = change_amt;
               state_next      = (change_amt == 8'd0) ? IDLE : CHANGE;
            end else begin
               state_next = REFUND;
            end
         end

         CHANGE: begin
            if (credit_reg >= 8'd4 && bank_u_reg != '0) begin
               out_fire = 1'b1;
               out_type = 2'd2;
            end else if (credit_reg >= 8'd2 && bank_h_reg != '0) begin
               out_fire = 1'b1;
               out_type = 2'd1;
            end else if (credit_reg != 8'd0 && bank_q_reg != '0) begin
               out_fire = 1'b1;
               out_type = 2'd0;
            end
            // A stuck plan cannot occur after a feasible CHECK; bail out to IDLE regardless.
            if (!out_fire || credit_reg == coin_value(out_type))
               state_next = IDLE;
         end

         REFUND: begin
            if (ins_u_reg != 8'd0) begin
               out_fire   = 1'b1;
               out_type   = 2'd2;
               ins_u_next = ins_u_reg - 8'd1;
            end else if (ins_h_reg != 8'd0) begin
               out_fire   = 1'b1;
               out_type   = 2'd1;
               ins_h_next = ins_h_reg - 8'd1;
            end else if (ins_q_reg != 8'd0) begin
               out_fire   = 1'b1;
               out_type   = 2'd0;
               ins_q_next = ins_q_reg - 8'd1;
            end
            if (ins_u_next == 8'd0 && ins_h_next == 8'd0 && ins_q_next == 8'd0)
               state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase

      if (coin_valid && state_reg != CREDIT)
         coin_rej_next = 1'b1;

      if (accept) begin
         credit_next = credit_reg + coin_amt;
         case (coin_type)
            2'd0: begin
               bank_q_next = bank_q_reg + CW'(1);
               ins_q_next  = ins_q_reg + 8'd1;
            end
            2'd1: begin
               bank_h_next = bank_h_reg + CW'(1);
               ins_h_next  = ins_h_reg + 8'd1;
            end
            default: begin
               bank_u_next = bank_u_reg + CW'(1);
               ins_u_next  = ins_u_reg + 8'd1;
            end
         endcase
      end

      if (out_fire) begin
         credit_next         = credit_reg - coin_value(out_type);
         coin_out_valid_next = 1'b1;
         coin_out_type_next  = out_type;
         case (out_type)
            2'd0:    bank_q_next = bank_q_reg - CW'(1);
            2'd1:    bank_h_next = bank_h_reg - CW'(1);
            default: bank_u_next = bank_u_reg - CW'(1);
         endcase
      end

      if (state_next == IDLE) begin
         credit_next = 8'd0;
         ins_q_next  = 8'd0;
         ins_h_next  = 8'd0;
         ins_u_next  = 8'd0;
      end
   end

`ifdef VEND_TIMEOUT_EN
   // Counts consecutive coin-less CREDIT cycles; restarts on every accepted coin.
   always_comb begin
      timer_next = '0;
      if (state_reg == CREDIT && state_next == CREDIT && !accept)
         timer_next = timer_reg + TW'(1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) timer_reg <= '0;
      else          timer_reg <= timer_next;
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg          <= IDLE;
         credit_reg         <= 8'd0;
         price_reg          <= 8'd0;
         id_reg             <= '0;
         bank_q_reg         <= CW'(INIT_COINS);
         bank_h_reg         <= CW'(INIT_COINS);
         bank_u_reg         <= CW'(INIT_COINS);
         ins_q_reg          <= 8'd0;
         ins_h_reg          <= 8'd0;
         ins_u_reg          <= 8'd0;
         sales_reg          <= 16'd0;
         vend_valid_reg     <= 1'b0;
         vend_id_reg        <= '0;
         coin_out_valid_reg <= 1'b0;
         coin_out_type_reg  <= 2'd0;
         coin_rej_reg       <= 1'b0;
         sel_err_reg        <= 1'b0;
      end else begin
         state_reg          <= state_next;
         credit_reg         <= credit_next;
         price_reg          <= price_next;
         id_reg             <= id_next;
         bank_q_reg         <= bank_q_next;
         bank_h_reg         <= bank_h_next;
         bank_u_reg         <= bank_u_next;
         ins_q_reg          <= ins_q_next;
         ins_h_reg          <= ins_h_next;
         ins_u_reg          <= ins_u_next;
         sales_reg          <= sales_next;
         vend_valid_reg     <= vend_valid_next;
         vend_id_reg        <= vend_id_next;
         coin_out_valid_reg <= coin_out_valid_next;
         coin_out_type_reg  <= coin_out_type_next;
         coin_rej_reg       <= coin_rej_next;
         sel_err_reg        <= sel_err_next;
      end
   end

   assign vend_valid     = vend_valid_reg;
   assign vend_id        = vend_id_reg;
   assign coin_out_valid = coin_out_valid_reg;
   assign coin_out_type  = coin_out_type_reg;
   assign coin_rej       = coin_rej_reg;
   assign sel_err        = sel_err_reg;
   assign refund_flag    = (state_reg == REFUND);
   assign busy           = (state_reg != IDLE);
   assign credit         = credit_reg;
   assign bank_q         = bank_q_reg;
   assign bank_h         = bank_h_reg;
   assign bank_u         = bank_u_reg;
   assign sales_total    = sales_reg;

endmodule

// File: tb/tb_vend_ctrl.sv
// Transaction-level bench for vend_ctrl: directed scenarios plus randomized transactions
// scored against a coin/price/bank model computed from the vending rules.
module tb_vend_ctrl;
   localparam int NPROD      = 4;
   localparam int CW         = 8;
   localparam int INIT_COINS = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          sel_valid = 1'b0;
   logic [1:0]    sel_id = '0;
   logic          coin_valid = 1'b0;
   logic [1:0]    coin_type = '0;
   logic          cancel = 1'b0;
   logic          price_wr = 1'b0;
   logic [1:0]    price_wr_id = '0;
   logic [7:0]    price_wr_val = '0;
   logic          vend_valid;
   logic [1:0]    vend_id;
   logic          coin_out_valid;
   logic [1:0]    coin_out_type;
   logic          coin_rej;
   logic          sel_err;
   logic          refund_flag;
   logic          busy;
   logic [7:0]    credit;
   logic [CW-1:0] bank_q, bank_h, bank_u;
   logic [15:0]   sales_total;

   vend_ctrl #(.NPROD(NPROD), .CW(CW), .INIT_COINS(INIT_COINS), .TIMEOUT(1000)) dut (
      .clock(clock), .reset_n(reset_n),
      .sel_valid(sel_valid), .sel_id(sel_id),
      .coin_valid(coin_valid), .coin_type(coin_type), .cancel(cancel),
      .price_wr(price_wr), .price_wr_id(price_wr_id), .price_wr_val(price_wr_val),
      .vend_valid(vend_valid), .vend_id(vend_id),
      .coin_out_valid(coin_out_valid), .coin_out_type(coin_out_type),
      .coin_rej(coin_rej), .sel_err(sel_err), .refund_flag(refund_flag), .busy(busy),
      .credit(credit), .bank_q(bank_q), .bank_h(bank_h), .bank_u(bank_u),
      .sales_total(sales_total)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference model (index 0 = 25c, 1 = 50c, 2 = 100c)
   int m_bank[3];
   int m_price[NPROD];
   int m_sales, m_credit, m_lprice, m_id;
   int m_ins[3];
   bit m_active;

   int exp_coins[$];
   int exp_vend[$];
   int exp_rej, exp_selerr, exp_refcyc;
   int obs_coins[$];
   int obs_vend[$];
   int obs_rej, obs_selerr, obs_refcyc;

   function automatic int cval(input int t);
      return (t == 0) ? 1 : (t == 1) ? 2 : 4;
   endfunction

   always @(negedge clock) begin
      if (reset_n) begin
         if (coin_out_valid) obs_coins.push_back(int'(coin_out_type));
         if (vend_valid)     obs_vend.push_back(int'(vend_id));
         if (coin_rej)       obs_rej++;
         if (sel_err)        obs_selerr++;
         if (refund_flag)    obs_refcyc++;
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin m_bank[i] = INIT_COINS; m_ins[i] = 0; end
      for (int i = 0; i < NPROD; i++) m_price[i] = i + 2;
      m_sales = 0; m_credit = 0; m_active = 0;
   endtask

   task automatic clear_board();
      exp_coins.delete(); exp_vend.delete(); obs_coins.delete(); obs_vend.delete();
      exp_rej = 0; exp_selerr = 0; exp_refcyc = 0;
      obs_rej = 0; obs_selerr = 0; obs_refcyc = 0;
   endtask

   task automatic drive(input bit sv, input int sid, input bit cv, input int ct, input bit cn,
                        input bit pw, input int pid, input int pval);
      @(negedge clock);
      sel_valid = sv; sel_id = 2'(sid);
      coin_valid = cv; coin_type = 2'(ct); cancel = cn;
      price_wr = pw; price_wr_id = 2'(pid); price_wr_val = 8'(pval);
   endtask

   task automatic quiet();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic write_price(input int id, input int val);
      drive(0, 0, 0, 0, 0, 1, id, val);
      quiet();
      m_price[id] = val;
   endtask

   task automatic select(input int id);
      drive(1, id, 0, 0, 0, 0, 0, 0);
      quiet();
      if (m_price[id] == 0) exp_selerr++;
      else begin
         m_active = 1; m_id = id; m_lprice = m_price[id]; m_credit = 0;
         for (int i = 0; i < 3; i++) m_ins[i] = 0;
      end
   endtask

   task automatic idle_coin(input int t);
      drive(0, 0, 1, t, 0, 0, 0, 0);
      quiet();
      exp_rej++;
   endtask

   task automatic coin(input int t, input bit cn, input bit sv, input bit pw, input int pid, input int pval);
      drive(sv, int'($urandom_range(0, 3)), 1, t, cn, pw, pid, pval);
      if (pw) m_price[pid] = pval;
      if (t != 3 && m_credit + cval(t) <= 255 && m_bank[t] < 255) begin
         m_credit += cval(t); m_bank[t]++; m_ins[t]++;
      end else exp_rej++;
      quiet();
      #1;
      check_val("credit", int'(credit), m_credit);
   endtask

   task automatic cancel_only();
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      quiet();
   endtask

   task automatic finish_txn(input bit cancelled);
      int ch, u, h, q, n, k;
      if (m_active) begin
         ch = m_credit - m_lprice;
         u = (m_bank[2] < ch / 4) ? m_bank[2] : ch / 4;
         h = (m_bank[1] < (ch - 4*u) / 2) ? m_bank[1] : (ch - 4*u) / 2;
         q = (m_bank[0] < ch - 4*u - 2*h) ? m_bank[0] : ch - 4*u - 2*h;
         if (cancelled || (4*u + 2*h + q != ch)) begin
            n = 0;
            for (int t = 2; t >= 0; t--)
               for (int j = 0; j < m_ins[t]; j++) begin
                  exp_coins.push_back(t); m_bank[t]--; n++;
               end
            exp_refcyc += (n == 0) ? 1 : n;
         end else begin
            exp_vend.push_back(m_id);
            m_sales = (m_sales + m_lprice) % 65536;
            for (int j = 0; j < u; j++) exp_coins.push_back(2);
            for (int j = 0; j < h; j++) exp_coins.push_back(1);
            for (int j = 0; j < q; j++) exp_coins.push_back(0);
            m_bank[2] -= u; m_bank[1] -= h; m_bank[0] -= q;
         end
      end
      m_active = 0; m_credit = 0;
      k = 0;
      while (busy && k < 1000) begin @(negedge clock); k++; end
      check_val("idle_wait_busy", int'(busy), 0);
      repeat (2) @(negedge clock);
      #1;
      check_val("coins_out_count", obs_coins.size(), exp_coins.size());
      for (int i = 0; i < obs_coins.size() && i < exp_coins.size(); i++)
         check_val("coin_out_type", obs_coins[i], exp_coins[i]);
      check_val("vend_count", obs_vend.size(), exp_vend.size());
      for (int i = 0; i < obs_vend.size() && i < exp_vend.size(); i++)
         check_val("vend_id", obs_vend[i], exp_vend[i]);
      check_val("coin_rej_count", obs_rej, exp_rej);
      check_val("sel_err_count", obs_selerr, exp_selerr);
      check_val("refund_cycles", obs_refcyc, exp_refcyc);
      check_val("bank_q", int'(bank_q), m_bank[0]);
      check_val("bank_h", int'(bank_h), m_bank[1]);
      check_val("bank_u", int'(bank_u), m_bank[2]);
      check_val("credit_idle", int'(credit), 0);
      check_val("sales_total", int'(sales_total), m_sales);
      clear_board();
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_busy"}, int'(busy), 0);
      check_val({tag, "_credit"}, int'(credit), 0);
      check_val({tag, "_sales"}, int'(sales_total), 0);
      check_val({tag, "_bank_q"}, int'(bank_q), INIT_COINS);
      check_val({tag, "_bank_h"}, int'(bank_h), INIT_COINS);
      check_val({tag, "_bank_u"}, int'(bank_u), INIT_COINS);
      check_val({tag, "_coin_out_valid"}, int'(coin_out_valid), 0);
      check_val({tag, "_vend_valid"}, int'(vend_valid), 0);
      check_val({tag, "_refund_flag"}, int'(refund_flag), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, r, t;
      bit cancelled;
      model_reset();
      clear_board();
      repeat (3) @(negedge clock);
      #1;
      check_reset_state("reset");
      @(negedge clock);
      reset_n = 1'b1;

      // Price 3, 100c in: one quarter back
      select(1);
      coin(2, 0, 0, 0, 0, 0);
      finish_txn(0);
      check_val("vend1_sales", int'(sales_total), 3);
      check_val("vend1_bank_u", int'(bank_u), 5);
      check_val("vend1_bank_q", int'(bank_q), 3);

      // Zero price makes the product unselectable
      write_price(3, 0);
      select(3);
      #1;
      check_val("zero_price_busy", int'(busy), 0);
      finish_txn(0);

      // Coin together with cancel is refunded with the earlier coin
      select(2);
      coin(0, 0, 0, 0, 0, 0);
      coin(1, 1, 0, 0, 0, 0);
      finish_txn(1);

      // Credit ceiling of 255 quarters
      write_price(3, 255);
      select(3);
      repeat (63) coin(2, 0, 0, 0, 0, 0);
      coin(1, 0, 0, 0, 0, 0);
      coin(1, 0, 0, 0, 0, 0);
      check_val("ceiling_credit", int'(credit), 254);
      cancel_only();
      finish_txn(1);

      // Reset while change is being paid out
      select(0);
      coin(0, 0, 0, 0, 0, 0);
      coin(2, 0, 0, 0, 0, 0);
      k = 0;
      do begin @(negedge clock); k++; end while (!coin_out_valid && k < 20);
      check_val("change_started", int'(coin_out_valid), 1);
      #2 reset_n = 1'b0;
      #1;
      check_reset_state("midchange_reset");
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      clear_board();

      // Drain 50c then 25c banks, then change for 2 quarters is impossible
      repeat (6) begin
         select(0);
         coin(2, 0, 0, 0, 0, 0);
         finish_txn(0);
      end
      check_val("drained_bank_q", int'(bank_q), 0);
      check_val("drained_bank_h", int'(bank_h), 0);
      select(0);
      coin(2, 0, 0, 0, 0, 0);
      finish_txn(0);
      check_val("infeasible_sales", int'(sales_total), 12);

      // Randomized transactions
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 4) == 0) write_price(int'($urandom_range(0, NPROD-1)), int'($urandom_range(0, 12)));
         if ($urandom_range(0, 6) == 0) idle_coin(int'($urandom_range(0, 3)));
         select(int'($urandom_range(0, NPROD-1)));
         cancelled = 0;
         if (m_active) begin
            for (int i = 0; i < 40 && m_credit < m_lprice; i++) begin
               r = int'($urandom_range(0, 19));
               t = int'($urandom_range(0, 9));
               t = (t < 3) ? 0 : (t < 6) ? 1 : (t < 9) ? 2 : 3;
               if (r == 0) begin
                  cancel_only(); cancelled = 1; break;
               end else if (r == 1) begin
                  coin(t, 1, 0, 0, 0, 0); cancelled = 1; break;
               end else begin
                  coin(t, 0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                       int'($urandom_range(0, NPROD-1)), int'($urandom_range(0, 12)));
               end
            end
            if (!cancelled && m_credit < m_lprice) begin
               cancel_only(); cancelled = 1;
            end
         end
         finish_txn(cancelled);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
